line_unpacker_512to256: RTL and testbench
=========================================

// Module: line_unpacker_512to256
// PURPOSE
//  Width down-converter: accepts full-width lines (default 512b) and emits them as
//  RATIO narrow beats (default 2 x 256b), most-significant slice first. Inverse of the
//  kernel's 256->512 line-assembly path (first word lands in [511:256]), so a line packed
//  upstream unpacks in original word order. Sits between line-wide kernel stages and
//  256b host/CCI-side write logic; valid/ready on both sides; full throughput.
// PARAMETERS
//  IN_WIDTH   512  input line width, bits
//  OUT_WIDTH  256  output beat width; IN_WIDTH % OUT_WIDTH == 0
//  RATIO      IN_WIDTH/OUT_WIDTH (derived localparam, >=2)
//  CNT_W      $clog2(RATIO) (derived localparam)
// PORTS
//  clk         in   1          clock, all state on posedge
//  reset       in   1          asynchronous, active-high
//  in_valid    in   1          input line valid
//  in_ready    out  1          block can take a line this cycle
//  in_data     in   IN_WIDTH   line; slice k = [IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH]
//  in_nbeats_m1 in  CNT_W      valid slices in line minus 1 (RATIO-1 = full line)
//  in_last     in   1          line ends the stream
//  out_valid   out  1          output beat valid
//  out_ready   in   1          downstream accepts beat
//  out_data    out  OUT_WIDTH  current slice
//  out_last    out  1          final beat of a line tagged in_last
// BEHAVIOUR
//  - State: hold_data, hold_nbm1, hold_last, full flag, beat counter (CNT_W).
//  - Reset (async assert, sync-safe deassert): full=0, beat=0, hold_*=0 ->
//    out_valid=0, out_data=0, out_last=0, in_ready=1. Reset mid-line discards held line.
//  - in_ready = !full | (out_valid & out_ready & beat==hold_nbm1) (combinational).
//  - Accept (in_valid & in_ready): capture in_data/in_nbeats_m1/in_last, full=1, beat=0.
//    Latency: first beat valid the cycle after acceptance.
//  - out_valid = full; out_data = slice[beat] of hold_data; out_last = hold_last & beat==hold_nbm1.
//  - Beat transfer (out_valid & out_ready): beat<hold_nbm1 -> beat+1; beat==hold_nbm1 ->
//    line retires: full=0 unless a new line accepted same cycle (then reload, beat=0).
//  - Last beat + new accept in same cycle: no bubble; RATIO beats per line back-to-back.
//  - Stall: out_valid & !out_ready -> out_data, out_last, beat frozen; in_ready=0 while full.
//  - Partial line (in_nbeats_m1<RATIO-1): only leading slices emitted, rest dropped.
//  - Beat counter never exceeds hold_nbm1; no wrap past RATIO-1.
//  - in_data ignored when !in_valid; no X propagation to out_data after reset.
// STRUCTURE
//  - Shared package: IN_WIDTH/OUT_WIDTH defaults, line/beat width constants, shared with
//    the 256->512 assembly path so both ends agree on slice order.
//  - Single module; slice mux is an indexed part-select, no sub-module needed.
// TESTING
//  1 Reset: assert reset mid-line -> out_valid=0, out_data=0, in_ready=1 immediately (async).
//  2 Line 512'h{A..A(256b),B..B(256b)}, nbm1=1, out_ready=1 -> beats A then B on
//    consecutive cycles, out_last=0 on both.
//  3 Three back-to-back full lines, out_ready=1 always -> 6 beats, no gaps, in_ready high
//    on every beat-1 cycle; last line in_last=1 -> out_last only on 6th beat.
//  4 Backpressure: out_ready=0 for 5 cycles on beat 0 -> out_data held = upper slice,
//    in_ready=0; release -> upper then lower slice, then in_ready=1.
//  5 Partial: in_nbeats_m1=0, in_last=1, data upper=C -> single beat C with out_last=1,
//    lower half never emitted.
//  6 Round trip: random stream through 256->512 assembly then this block, random
//    valid/ready gaps -> output beat sequence identical to original input sequence.

Source files
------------

// File: rtl/line_unpacker_512to256_pkg.sv
// Widths shared by the 256->512 line-assembly path and the 512->256 unpacker.
// Both ends use the same slice order: the first word of a line lives in the top slice.
package line_unpacker_512to256_pkg;

   localparam int LU_IN_WIDTH  = 512;
   localparam int LU_OUT_WIDTH = 256;
   localparam int LU_RATIO     = LU_IN_WIDTH / LU_OUT_WIDTH;
   localparam int LU_CNT_W     = $clog2(LU_RATIO);

   // Bit index of the MSB of slice k inside a line; slice 0 is the first word on the wire.
   function automatic int slice_msb(input int line_w, input int beat_w, input int k);
      return line_w - 1 - k * beat_w;
   endfunction

endpackage

// File: rtl/line_unpacker_512to256.sv
// Line-to-beat width down-converter: each held line is emitted as up to RATIO narrow
// beats, top slice first, with valid/ready on both sides and no bubble between lines.
module line_unpacker_512to256
   import line_unpacker_512to256_pkg::*;
#(
   parameter int  IN_WIDTH  = LU_IN_WIDTH,
   parameter int  OUT_WIDTH = LU_OUT_WIDTH,
   localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
   localparam int CNT_W     = $clog2(RATIO)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic [CNT_W-1:0]     in_nbeats_m1,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last
);

   localparam logic [CNT_W-1:0] MAX_BEAT = CNT_W'(RATIO - 1);

   logic [IN_WIDTH-1:0] hold_data_q, hold_data_d;
   logic [CNT_W-1:0]    hold_nbm1_q, hold_nbm1_d;
   logic                hold_last_q, hold_last_d;
   logic                full_q, full_d;
   logic [CNT_W-1:0]    beat_q, beat_d;

   logic out_fire;
   logic last_beat;
   logic accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_data_q <= '0;
         hold_nbm1_q <= '0;
         hold_last_q <= 1'b0;
         full_q      <= 1'b0;
         beat_q      <= '0;
      end else begin
         hold_data_q <= hold_data_d;
         hold_nbm1_q <= hold_nbm1_d;
         hold_last_q <= hold_last_d;
         full_q      <= full_d;
         beat_q      <= beat_d;
      end
   end

   always_comb begin
      out_fire  = full_q & out_ready;
      last_beat = (beat_q == hold_nbm1_q);
      // A line may enter on the same cycle the previous one hands over its final beat.
      in_ready  = ~full_q | (out_fire & last_beat);
      accept    = in_valid & in_ready;

      hold_data_d = hold_data_q;
      hold_nbm1_d = hold_nbm1_q;
      hold_last_d = hold_last_q;
      full_d      = full_q;
      beat_d      = beat_q;

      if (out_fire) begin
         if (last_beat) begin
            full_d = 1'b0;
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end

      if (accept) begin
         hold_data_d = in_data;
         // Out-of-range counts (possible when RATIO is not a power of two) saturate.
         hold_nbm1_d = (in_nbeats_m1 > MAX_BEAT) ? MAX_BEAT : in_nbeats_m1;
         hold_last_d = in_last;
         full_d      = 1'b1;
         beat_d      = '0;
      end
   end

   always_comb begin
      out_valid = full_q;
      out_last  = hold_last_q & last_beat;
      out_data  = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (beat_q == CNT_W'(k)) begin
            out_data = hold_data_q[slice_msb(IN_WIDTH, OUT_WIDTH, k) -: OUT_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_line_unpacker_512to256.sv
// Bench for line_unpacker_512to256: directed cases plus a randomized round trip through
// a behavioural 256->512 assembler, checked against a queue of expected {last, beat}.
module tb_line_unpacker_512to256;
   import line_unpacker_512to256_pkg::*;

   localparam int IW = LU_IN_WIDTH;
   localparam int OW = LU_OUT_WIDTH;
   localparam int CW = LU_CNT_W;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_data;
   logic [CW-1:0] in_nbeats_m1;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          out_last;

   logic rand_rdy;
   logic rnd_rdy;
   logic rdy_force;
   assign out_ready = rand_rdy ? rnd_rdy : rdy_force;

   int n_checks;
   int n_errors;
   int cyc;
   logic [OW:0] exp_q[$];
   int beat_cyc_q[$];

   line_unpacker_512to256 dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_nbeats_m1 (in_nbeats_m1),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [OW:0] act, input logic [OW:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Scoreboard: every accepted output beat must match the head of exp_q.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         beat_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            check_eq("sb_extra_beat", {1'b0, out_data}, '0);
         end else begin
            check_eq("sb_beat", {out_last, out_data}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a posedge; returns just after the posedge that accepted the line.
   task automatic send_line(input logic [IW-1:0] data, input logic [CW-1:0] nbm1,
                            input logic last, output int waits);
      bit done;
      done         = 0;
      waits        = 0;
      in_valid     = 1'b1;
      in_data      = data;
      in_nbeats_m1 = nbm1;
      in_last      = last;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1;
         else waits++;
         @(posedge clk);
         #1;
      end
      if (!done) check_eq("send_timeout", 0, 1);
      in_valid = 1'b0;
      in_data  = {IW{1'b1}};
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      bit done;
      done = 0;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) done = 1;
      end
      if (!done) check_eq("drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [OW-1:0] rnd_word();
      logic [OW-1:0] w;
      for (int i = 0; i < OW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // ---------------- stimulus ----------------
   logic [OW-1:0] wa, wb, wc, wd;
   logic [OW-1:0] words[$];
   logic [IW-1:0] line;
   int w;

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      cyc       = 0;
      rand_rdy  = 1'b0;
      rdy_force = 1'b1;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_nbeats_m1 = '0;
      in_last   = 1'b0;
      wa = {(OW/4){4'hA}};
      wb = {(OW/4){4'hB}};
      wc = {(OW/4){4'hC}};
      wd = {(OW/4){4'hD}};

      #2;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_last", out_last, 0);
      idle(2);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;

      // Reset mid-line: held line must vanish immediately.
      rdy_force = 1'b0;
      send_line({wa, wb}, 1'b1, 1'b1, w);
      #2;
      check_eq("mid_pre_valid", out_valid, 1);
      reset = 1'b1;
      exp_q.delete();
      #1;
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_out_data", out_data, 0);
      check_eq("mid_rst_in_ready", in_ready, 1);
      check_eq("mid_rst_out_last", out_last, 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
      rdy_force = 1'b1;
      @(negedge clk);
      check_eq("post_rst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;

      // Single full line, not last: A then B on consecutive cycles.
      beat_cyc_q.delete();
      exp_q.push_back({1'b0, wa});
      exp_q.push_back({1'b0, wb});
      send_line({wa, wb}, 1'b1, 1'b0, w);
      check_eq("t2_wait", w, 0);
      wait_drain();
      check_eq("t2_nbeats", beat_cyc_q.size(), 2);
      if (beat_cyc_q.size() == 2) check_eq("t2_gap", beat_cyc_q[1] - beat_cyc_q[0], 1);

      // Three back-to-back lines: 6 gapless beats, in_ready seen on each beat-1 cycle.
      beat_cyc_q.delete();
      for (int l = 0; l < 3; l++) begin
         logic [OW-1:0] hi, lo;
         hi = rnd_word();
         lo = rnd_word();
         exp_q.push_back({1'b0, hi});
         exp_q.push_back({(l == 2) ? 1'b1 : 1'b0, lo});
         send_line({hi, lo}, 1'b1, (l == 2), w);
         check_eq("t3_wait", w, (l == 0) ? 0 : 1);
      end
      wait_drain();
      check_eq("t3_nbeats", beat_cyc_q.size(), 6);
      if (beat_cyc_q.size() == 6) check_eq("t3_span", beat_cyc_q[5] - beat_cyc_q[0], 5);

      // Backpressure on beat 0 for five cycles.
      rdy_force = 1'b0;
      exp_q.push_back({1'b0, wc});
      exp_q.push_back({1'b1, wd});
      send_line({wc, wd}, 1'b1, 1'b1, w);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("t4_hold_data", out_data, wc);
         check_eq("t4_hold_rdy", in_ready, 0);
      end
      @(posedge clk);
      #1;
      rdy_force = 1'b1;
      wait_drain();
      check_eq("t4_in_ready_after", in_ready, 1);

      // Partial line: only the upper slice leaves, tagged last.
      exp_q.push_back({1'b1, wc});
      send_line({wc, wd}, 1'b0, 1'b1, w);
      wait_drain();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t5_no_lower", out_valid, 0);
      end
      @(posedge clk);
      #1;

      // Round trip: random word stream packed first-word-high, random gaps both sides.
      words.delete();
      for (int i = 0; i < 41; i++) words.push_back(rnd_word());
      for (int i = 0; i < words.size(); i++)
         exp_q.push_back({(i == words.size() - 1) ? 1'b1 : 1'b0, words[i]});
      rand_rdy = 1'b1;
      for (int i = 0; i < words.size(); i += 2) begin
         bit pair;
         pair = (i + 1 < words.size());
         line = '0;
         line[IW-1 -: OW] = words[i];
         if (pair) line[OW-1:0] = words[i+1];
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         send_line(line, pair ? CW'(1) : CW'(0), (i + 2 >= words.size()), w);
      end
      wait_drain();
      rand_rdy = 1'b0;
      check_eq("t6_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
